marquee_ctrl: RTL and testbench
===============================

MARQUEE_CTRL -- requirements
Module: marquee_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000000, clk50 cycles per base tick; legal range >=2.
REQ-002 Parameter SLOW_MULT, default 4, base ticks per step in SLOW mode; legal range >=1.
REQ-003 Parameter DEB_CYCLES, default 1000000, stable-level cycles required to accept a key; legal range >=1.
REQ-004 clk50  input  1  sole clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset; asynchronous, active-high.
REQ-006 key0  input  1  asynchronous, active-high button; request FAST mode.
REQ-007 key1  input  1  asynchronous, active-high button; request SLOW mode.
REQ-008 key2  input  1  asynchronous, active-high button; pause/resume toggle.
REQ-009 dir  input  1  rotation direction; 0 = forward (S increments), 1 = reverse; sampled on the step edge.
REQ-010 S  output  3  rotation index 0..4, which drives the five-digit display decoder.
REQ-011 step  output  1  one-cycle pulse, high in the first cycle a new S value is present.
REQ-012 mode  output  2  00 FAST, 01 SLOW, 10 PAUSED; 11 never driven.

Function
REQ-013 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Debounce: the debounced level SHALL take the synchronized value only after it has differed from the current debounced level for DEB_CYCLES consecutive cycles; any reversion SHALL restart the count.
REQ-015 A press pulse SHALL be generated for one cycle on each 0->1 transition of a debounced level; releases SHALL generate nothing.
REQ-016 Prescaler: free-running counter 0..CLK_DIV-1, wrapping to 0; base tick SHALL be high in the cycle count==CLK_DIV-1; it SHALL run in all modes.
REQ-017 FAST: every base tick SHALL cause a step.
REQ-018 SLOW: a slow counter 0..SLOW_MULT-1 SHALL advance on each base tick; a step SHALL occur on the base tick where the counter is SLOW_MULT-1, after which the counter wraps to 0.
REQ-019 PAUSED: no step; S, the slow counter and the prescaler phase are held or run as follows: S held, slow counter held, prescaler running.
REQ-020 Step forward: S <= (S==4) ? 0 : S+1. Step reverse: S <= (S==0) ? 4 : S-1. S SHALL never hold 5..7.
REQ-021 Step latency: a base tick in cycle N SHALL produce an updated S and step=1 in cycle N+1.
REQ-022 Mode FSM transitions on press pulses, taking effect the next cycle:
  - key0 press: to FAST from any state.
  - key1 press: to SLOW from any state.
  - key2 press: FAST/SLOW -> PAUSED with the prior mode saved; PAUSED -> saved mode.
REQ-023 Simultaneous press pulses in one cycle: priority key2 > key1 > key0; lower-priority pulses in that cycle SHALL be discarded.
REQ-024 Any mode transition SHALL clear the slow counter to 0; the prescaler SHALL NOT be cleared.
REQ-025 If a mode transition and a base tick coincide, the step decision SHALL use the old mode.

Reset
REQ-026 While clr=1, regardless of clk50: S=0, step=0, mode=00, saved mode=FAST, prescaler=0, slow counter=0, all synchronizer flops, debounce counters and debounced levels=0.
REQ-027 On clr deassertion mid-rotation, the first step SHALL occur exactly CLK_DIV cycles after the first clock edge following release.
REQ-028 A key held during and after reset SHALL register as one press after the normal sync+debounce latency.

Verification (CLK_DIV=4, SLOW_MULT=4, DEB_CYCLES=3)
REQ-029 Reset, then 40 cycles in FAST with dir=0 -> S sequence 1,2,3,4,0,... with one change every 4 cycles; step high exactly 10 times.
REQ-030 dir=1 from S=0 -> next step gives S=4, then S=3.
REQ-031 key1 held 10 cycles -> mode=01 after 2+3+1 cycles; steps then every 16 cycles.
REQ-032 key2 pulsed high for 2 cycles (glitch) -> no mode change; held for 6 cycles -> PAUSED, S frozen for 50 cycles; second press -> resumes SLOW.
REQ-033 key0 and key2 debounced in the same cycle while FAST -> mode=10; key0 ignored.
REQ-034 clr asserted between clock edges while S=3 and mode=01 -> S=0 and mode=00 immediately; first step 4 cycles after release.

Source files
------------

// File: rtl/marquee_ctrl.sv
// marquee_ctrl -- rotating-index controller for a five-digit marquee display.
//
// A free-running prescaler produces a base tick every CLK_DIV cycles. In FAST
// mode every base tick advances the rotation index S; in SLOW mode only every
// SLOW_MULT-th base tick does; in PAUSED mode S is frozen. Three push buttons
// select the mode after synchronisation, debouncing and rising-edge detection.
//
// Ports:
//   clk50  in   1  sole clock, rising edge
//   clr    in   1  asynchronous active-high reset
//   key0   in   1  async button, request FAST
//   key1   in   1  async button, request SLOW
//   key2   in   1  async button, pause/resume toggle
//   dir    in   1  0 = forward (S increments), 1 = reverse
//   S      out  3  rotation index 0..4
//   step   out  1  one-cycle pulse in the first cycle a new S is present
//   mode   out  2  00 FAST, 01 SLOW, 10 PAUSED
module marquee_ctrl #(
  parameter int CLK_DIV    = 50000000,
  parameter int SLOW_MULT  = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk50,
  input  logic       clr,
  input  logic       key0,
  input  logic       key1,
  input  logic       key2,
  input  logic       dir,
  output logic [2:0] S,
  output logic       step,
  output logic [1:0] mode
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = (SLOW_MULT > 1) ? $clog2(SLOW_MULT) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_MULT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    M_FAST   = 2'b00,
    M_SLOW   = 2'b01,
    M_PAUSED = 2'b10
  } mode_t;

  // ---------------------------------------------------------------------------
  // Key synchronisers (bit 0 = key0, bit 1 = key1, bit 2 = key2)
  // ---------------------------------------------------------------------------
  logic [2:0] keys_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;

  assign keys_raw = {key2, key1, key0};

  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers sample the values from before the edge, independent of order.
  always_ff @(posedge clk50 or posedge clr) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the level flips only after the synchronised input has disagreed
  // with it for DEB_CYCLES consecutive cycles; any agreement restarts the count.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    deb;
  logic [2:0]    deb_q;
  logic [2:0]    press;

  // NOTE: the debounce counters are a small register array, not a RAM, so
  // they are cleared by reset like any other flop.
  always_ff @(posedge clk50 or posedge clr) begin
    if (clr) begin
      deb <= '0;
      for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] != deb[k]) begin
          if (deb_cnt[k] == DEB_LAST) begin
            deb[k]     <= sync2[k];
            deb_cnt[k] <= '0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          end
        end else begin
          deb_cnt[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk50 or posedge clr) begin
    if (clr) deb_q <= '0;
    else     deb_q <= deb;
  end

  // One-cycle pulse on each debounced 0->1 transition; releases are ignored.
  assign press = deb & ~deb_q;

  // ---------------------------------------------------------------------------
  // Prescaler: runs in every mode and is never cleared by mode changes.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic          base_tick;

  assign base_tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk50 or posedge clr) begin
    if (clr)            pre_cnt <= '0;
    else if (base_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  mode_t state, next_state;
  mode_t saved, saved_next;
  logic  mode_change;

  always_ff @(posedge clk50 or posedge clr) begin
    if (clr) begin
      state <= M_FAST;
      saved <= M_FAST;
    end else begin
      state <= next_state;
      saved <= saved_next;
    end
  end

  // key2 outranks key1, which outranks key0; losers in the same cycle are lost.
  // NOTE: defaults at the top of the block keep every path assigned, so no
  // latch is inferred.
  always_comb begin
    next_state = state;
    saved_next = saved;
    if (press[2]) begin
      if (state == M_PAUSED) begin
        next_state = saved;
      end else begin
        next_state = M_PAUSED;
        saved_next = state;
      end
    end else if (press[1]) begin
      next_state = M_SLOW;
    end else if (press[0]) begin
      next_state = M_FAST;
    end
  end

  always_comb begin
    mode        = state;
    mode_change = (next_state != state);
  end

  // ---------------------------------------------------------------------------
  // Step generation. Decisions use the current (old) mode, so a base tick that
  // coincides with a mode change still follows the mode being left.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] slow_cnt;
  logic          do_step;

  assign do_step = base_tick &&
                   ((state == M_FAST) ||
                    ((state == M_SLOW) && (slow_cnt == SLOW_LAST)));

  always_ff @(posedge clk50 or posedge clr) begin
    if (clr) begin
      slow_cnt <= '0;
    end else if (mode_change) begin
      slow_cnt <= '0;
    end else if ((state == M_SLOW) && base_tick) begin
      slow_cnt <= (slow_cnt == SLOW_LAST) ? '0 : slow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk50 or posedge clr) begin
    if (clr) begin
      S    <= 3'd0;
      step <= 1'b0;
    end else begin
      step <= do_step;
      if (do_step) begin
        if (dir) S <= (S == 3'd0) ? 3'd4 : S - 3'd1;
        else     S <= (S == 3'd4) ? 3'd0 : S + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_marquee_ctrl.sv
// Testbench for marquee_ctrl with CLK_DIV=4, SLOW_MULT=4, DEB_CYCLES=3.
// A table of {held keys, dir, edge count, expected S/step/mode} records drives
// the timeline; expected values go through a scoreboard queue and are compared
// one cycle-sample at a time. The asynchronous-reset sequence is hand-written.
module tb_marquee_ctrl;

  localparam logic [1:0] FAST   = 2'b00;
  localparam logic [1:0] SLOW   = 2'b01;
  localparam logic [1:0] PAUSED = 2'b10;

  logic       clk50;
  logic       clr;
  logic       key0, key1, key2;
  logic       dir;
  logic [2:0] S;
  logic       step;
  logic [1:0] mode;

  marquee_ctrl #(
    .CLK_DIV   (4),
    .SLOW_MULT (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk50(clk50),
    .clr  (clr),
    .key0 (key0),
    .key1 (key1),
    .key2 (key2),
    .dir  (dir),
    .S    (S),
    .step (step),
    .mode (mode)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  typedef struct {
    string      name;
    int         edges;   // clock edges to run with these inputs held
    logic [2:0] keys;    // {key2, key1, key0}
    logic       dir;
    logic [2:0] exp_s;
    logic       exp_step;
    logic [1:0] exp_mode;
    logic       each;    // compare after every edge, not only the last
  } vec_t;

  typedef struct {
    logic [2:0] s;
    logic       step;
    logic [1:0] mode;
  } exp_t;

  vec_t tbl[$];
  vec_t rst_tbl[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input string name, input int edges,
                              input logic [2:0] keys, input logic d,
                              input logic [2:0] s, input logic st,
                              input logic [1:0] m, input logic each);
    vec_t v;
    v.name     = name;
    v.edges    = edges;
    v.keys     = keys;
    v.dir      = d;
    v.exp_s    = s;
    v.exp_step = st;
    v.exp_mode = m;
    v.each     = each;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] s, input logic st, input logic [1:0] m);
    exp_t e;
    e.s    = s;
    e.step = st;
    e.mode = m;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, ".scoreboard_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check({name, ".S"},    8'(S),    8'(e.s));
      check({name, ".step"}, 8'(step), 8'(e.step));
      check({name, ".mode"}, 8'(mode), 8'(e.mode));
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic advance();
    @(posedge clk50);
    #1;
  endtask

  task automatic apply(input vec_t v);
    {key2, key1, key0} = v.keys;
    dir = v.dir;
    for (int i = 0; i < v.edges; i++) begin
      advance();
      if (v.each || i == v.edges - 1) begin
        push_exp(v.exp_s, v.exp_step, v.exp_mode);
        pop_compare(v.name);
      end
    end
  endtask

  initial begin
    int nsteps;
    // Timeline from reset release; E is the edge count after release.
    tbl.push_back(mk("rev_first",    4, 3'b000, 1'b1, 3'd4, 1'b1, FAST,   1'b0)); // E=44
    tbl.push_back(mk("rev_second",   4, 3'b000, 1'b1, 3'd3, 1'b1, FAST,   1'b0)); // E=48
    tbl.push_back(mk("rev_idle",     1, 3'b000, 1'b0, 3'd3, 1'b0, FAST,   1'b0)); // E=49
    tbl.push_back(mk("k1_latency",   5, 3'b010, 1'b0, 3'd4, 1'b0, FAST,   1'b0)); // E=54
    tbl.push_back(mk("k1_slow",      1, 3'b010, 1'b0, 3'd4, 1'b0, SLOW,   1'b0)); // E=55
    tbl.push_back(mk("k1_hold",      4, 3'b010, 1'b0, 3'd4, 1'b0, SLOW,   1'b1)); // E=59
    tbl.push_back(mk("slow_wait1",   8, 3'b000, 1'b0, 3'd4, 1'b0, SLOW,   1'b1)); // E=67
    tbl.push_back(mk("slow_step1",   1, 3'b000, 1'b0, 3'd0, 1'b1, SLOW,   1'b0)); // E=68
    tbl.push_back(mk("slow_wait2",  15, 3'b000, 1'b0, 3'd0, 1'b0, SLOW,   1'b1)); // E=83
    tbl.push_back(mk("slow_step2",   1, 3'b000, 1'b0, 3'd1, 1'b1, SLOW,   1'b0)); // E=84
    tbl.push_back(mk("k2_glitch",    2, 3'b100, 1'b0, 3'd1, 1'b0, SLOW,   1'b1)); // E=86
    tbl.push_back(mk("glitch_none",  9, 3'b000, 1'b0, 3'd1, 1'b0, SLOW,   1'b1)); // E=95
    tbl.push_back(mk("slow_step3",   5, 3'b000, 1'b0, 3'd2, 1'b1, SLOW,   1'b0)); // E=100
    tbl.push_back(mk("k2_hold",      5, 3'b100, 1'b0, 3'd2, 1'b0, SLOW,   1'b1)); // E=105
    tbl.push_back(mk("k2_pause",     1, 3'b100, 1'b0, 3'd2, 1'b0, PAUSED, 1'b0)); // E=106
    tbl.push_back(mk("pause_freeze",50, 3'b000, 1'b0, 3'd2, 1'b0, PAUSED, 1'b1)); // E=156
    tbl.push_back(mk("k2_again",     5, 3'b100, 1'b0, 3'd2, 1'b0, PAUSED, 1'b1)); // E=161
    tbl.push_back(mk("resume_slow",  1, 3'b100, 1'b0, 3'd2, 1'b0, SLOW,   1'b0)); // E=162
    tbl.push_back(mk("resume_wait", 13, 3'b000, 1'b0, 3'd2, 1'b0, SLOW,   1'b1)); // E=175
    tbl.push_back(mk("resume_step",  1, 3'b000, 1'b0, 3'd3, 1'b1, SLOW,   1'b0)); // E=176
    tbl.push_back(mk("k0_hold",      5, 3'b001, 1'b0, 3'd3, 1'b0, SLOW,   1'b1)); // E=181
    tbl.push_back(mk("k0_fast",      1, 3'b001, 1'b0, 3'd3, 1'b0, FAST,   1'b0)); // E=182
    tbl.push_back(mk("fast_step_a",  2, 3'b000, 1'b0, 3'd4, 1'b1, FAST,   1'b0)); // E=184
    tbl.push_back(mk("fast_step_b",  6, 3'b000, 1'b0, 3'd0, 1'b0, FAST,   1'b0)); // E=190
    tbl.push_back(mk("k0k2_step",    2, 3'b101, 1'b0, 3'd1, 1'b1, FAST,   1'b0)); // E=192
    tbl.push_back(mk("k0k2_wait",    3, 3'b101, 1'b0, 3'd1, 1'b0, FAST,   1'b1)); // E=195
    tbl.push_back(mk("k0k2_pause",   1, 3'b101, 1'b0, 3'd2, 1'b1, PAUSED, 1'b0)); // E=196 tick+change
    tbl.push_back(mk("k0_ignored",   8, 3'b000, 1'b0, 3'd2, 1'b0, PAUSED, 1'b1)); // E=204
    tbl.push_back(mk("k2_resume",    5, 3'b100, 1'b0, 3'd2, 1'b0, PAUSED, 1'b1)); // E=209
    tbl.push_back(mk("saved_fast",   1, 3'b100, 1'b0, 3'd2, 1'b0, FAST,   1'b0)); // E=210
    tbl.push_back(mk("fast_idle",    1, 3'b000, 1'b0, 3'd2, 1'b0, FAST,   1'b0)); // E=211
    tbl.push_back(mk("fast_step_c",  1, 3'b000, 1'b0, 3'd3, 1'b1, FAST,   1'b0)); // E=212
    tbl.push_back(mk("k1_again",     4, 3'b010, 1'b0, 3'd4, 1'b1, FAST,   1'b0)); // E=216
    tbl.push_back(mk("k1_slow2",     2, 3'b010, 1'b0, 3'd4, 1'b0, SLOW,   1'b0)); // E=218
    tbl.push_back(mk("slow_rev_w",  13, 3'b000, 1'b1, 3'd4, 1'b0, SLOW,   1'b1)); // E=231
    tbl.push_back(mk("slow_rev",     1, 3'b000, 1'b1, 3'd3, 1'b1, SLOW,   1'b0)); // E=232
    tbl.push_back(mk("slow_hold3",   2, 3'b000, 1'b1, 3'd3, 1'b0, SLOW,   1'b0)); // E=234

    // After the mid-rotation reset; key2 held through reset and afterwards.
    rst_tbl.push_back(mk("post_rst_e1", 1, 3'b100, 1'b0, 3'd0, 1'b0, FAST,   1'b0));
    rst_tbl.push_back(mk("post_rst_e2", 1, 3'b100, 1'b0, 3'd0, 1'b0, FAST,   1'b0));
    rst_tbl.push_back(mk("post_rst_e3", 1, 3'b100, 1'b0, 3'd0, 1'b0, FAST,   1'b0));
    rst_tbl.push_back(mk("post_rst_e4", 1, 3'b100, 1'b0, 3'd1, 1'b1, FAST,   1'b0));
    rst_tbl.push_back(mk("post_rst_e5", 1, 3'b100, 1'b0, 3'd1, 1'b0, FAST,   1'b0));
    rst_tbl.push_back(mk("held_key_e6", 1, 3'b100, 1'b0, 3'd1, 1'b0, PAUSED, 1'b0));
    rst_tbl.push_back(mk("held_key_e7", 1, 3'b100, 1'b0, 3'd1, 1'b0, PAUSED, 1'b0));
    rst_tbl.push_back(mk("held_key_e8", 1, 3'b100, 1'b0, 3'd1, 1'b0, PAUSED, 1'b0));
    rst_tbl.push_back(mk("held_key_e9", 6, 3'b100, 1'b0, 3'd1, 1'b0, PAUSED, 1'b1));

    // Reset state.
    clr = 1'b1;
    {key2, key1, key0} = 3'b000;
    dir = 1'b0;
    repeat (3) advance();
    push_exp(3'd0, 1'b0, FAST);
    pop_compare("reset_state");

    // Release between edges, then 40 cycles of FAST forward rotation.
    clr = 1'b0;
    nsteps = 0;
    for (int k = 1; k <= 40; k++) begin
      advance();
      if (step === 1'b1) nsteps++;
      push_exp(3'((k / 4) % 5), (k % 4) == 0, FAST);
      pop_compare($sformatf("fast_fwd_e%0d", k));
    end
    check("fast_step_count", 8'(nsteps), 8'd10);

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous clear between edges while S=3 and mode=SLOW.
    #2;
    clr = 1'b1;
    key2 = 1'b1;
    dir = 1'b0;
    #1;
    push_exp(3'd0, 1'b0, FAST);
    pop_compare("async_clr_immediate");
    for (int i = 0; i < 2; i++) begin
      advance();
      push_exp(3'd0, 1'b0, FAST);
      pop_compare($sformatf("clr_held_e%0d", i));
    end
    #2;
    clr = 1'b0;
    foreach (rst_tbl[i]) apply(rst_tbl[i]);

    key2 = 1'b0;
    repeat (4) advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
